// File: rtl/ghost_ship_gen.sv
// ghost_ship_gen
// ---------------
// Evaluates a requested ship placement (anchor tile, heading, length) against
// an external occupancy map and draws the result as a "ghost" overlay on the
// display.
//
// An update pulse in IDLE latches cursor/orientation/length. CALC builds the
// unclipped segment in signed arithmetic and clips it to the grid. SCAN reads
// every clipped tile from the occupancy map. COMMIT publishes the result to the
// display registers. The ghost overlay only reads the display registers, so a
// half-evaluated placement is never drawn.
//
// Ports
//   clk, rst          : clock, synchronous active-low reset
//   pixel_x, pixel_y  : raw display coordinates feeding the 2-stage ghost path
//   cursor            : {x[7:4], y[3:0]} anchor tile
//   orientation       : one-hot heading N=1, E=2, S=4, W=8
//   length            : ship length in tiles
//   update            : evaluation request, honoured only while idle
//   occ_addr/occ_data : occupancy map read port (data one cycle after address)
//   busy, done        : evaluation in progress / single-cycle commit pulse
//   placement_ok, oob, collide : committed evaluation result
//   ghost_ship, ghost_ok       : overlay hit and colour select, 2 cycles after pixel
module ghost_ship_gen #(
    parameter int GRID_N       = 10,
    parameter int TILE_LOG2    = 5,
    parameter int BANNER_TILES = 3,
    parameter int MAX_LEN      = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [7:0] cursor,
    input  logic [3:0] orientation,
    input  logic [3:0] length,
    input  logic       update,
    output logic [7:0] occ_addr,
    input  logic       occ_data,
    output logic       busy,
    output logic       done,
    output logic       placement_ok,
    output logic       oob,
    output logic       collide,
    output logic       ghost_ship,
    output logic       ghost_ok
);

    localparam logic signed [6:0] GMAX_S = 7'(GRID_N - 1);
    localparam logic [3:0]        GMAX4  = 4'(GRID_N - 1);
    localparam logic [3:0]        GRID4  = 4'(GRID_N);
    localparam logic [3:0]        MAXL4  = 4'(MAX_LEN);
    localparam logic [9:0]        GRID10 = 10'(GRID_N);
    localparam logic [9:0]        BAN10  = 10'(BANNER_TILES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SCAN,
        S_COMMIT
    } state_e;

    state_e state_q, state_d;

    // Request latched at acceptance
    logic [7:0] cur_q;
    logic [3:0] ori_q;
    logic [3:0] len_q;

    // Working (clipped) segment produced by CALC
    logic [3:0] wxlo_q, wxhi_q, wylo_q, wyhi_q;
    logic       wvert_q;
    logic [3:0] wspan_q;     // clipped length - 1
    logic       woob_q;
    logic       wempty_q;
    logic [4:0] cnt_q;       // SCAN cycle index
    logic       acc_q;       // collide accumulator
    logic [7:0] occ_addr_q;

    // Display copy, written only in COMMIT
    logic [3:0] dxlo_q, dxhi_q, dylo_q, dyhi_q;
    logic       dvalid_q;
    logic       dok_q;
    logic       doob_q;
    logic       dcol_q;

    // Pixel pipeline
    logic [9:0] tx_q, ty_q;
    logic       ing_q;
    logic       ghost_q, gok_q;

    // ------------------------------------------------------------------
    // CALC combinational segment builder
    // ------------------------------------------------------------------
    logic signed [6:0] cx_s, cy_s, len_s, base_s, lo_s, hi_s;
    logic [3:0]        lo_c, hi_c;
    logic              calc_vert, one_hot, calc_empty, calc_oob;
    logic [3:0]        seg_xlo, seg_xhi, seg_ylo, seg_yhi;

    always_comb begin
        cx_s      = $signed({3'b000, cur_q[7:4]});
        cy_s      = $signed({3'b000, cur_q[3:0]});
        len_s     = $signed({3'b000, len_q});
        calc_vert = ori_q[0] | ori_q[2];
        base_s    = calc_vert ? cy_s : cx_s;
        lo_s      = base_s;
        hi_s      = base_s;
        // NORTH/WEST grow toward smaller coordinates, SOUTH/EAST toward larger
        if (ori_q[0] | ori_q[3]) begin
            lo_s = base_s - len_s + 7'sd1;
        end else begin
            hi_s = base_s + len_s - 7'sd1;
        end

        one_hot = 1'b0;
        case (ori_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: one_hot = 1'b1;
            default:                            one_hot = 1'b0;
        endcase

        lo_c = (lo_s < 7'sd0)   ? 4'd0  : lo_s[3:0];
        hi_c = (hi_s > GMAX_S)  ? GMAX4 : hi_s[3:0];

        calc_empty = !one_hot || (len_q == 4'd0) ||
                     (cur_q[7:4] >= GRID4) || (cur_q[3:0] >= GRID4);
        calc_oob   = calc_empty || (lo_s < 7'sd0) || (hi_s > GMAX_S) ||
                     (len_q > MAXL4);

        seg_xlo = calc_vert ? cur_q[7:4] : lo_c;
        seg_xhi = calc_vert ? cur_q[7:4] : hi_c;
        seg_ylo = calc_vert ? lo_c       : cur_q[3:0];
        seg_yhi = calc_vert ? hi_c       : cur_q[3:0];
    end

    // SCAN spans clipped length + 1 cycles: the extra cycle catches the
    // sample returned for the final address.
    logic [4:0] scan_last;
    assign scan_last = {1'b0, wspan_q} + 5'd1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (update) state_d = S_CALC;
            S_CALC:   state_d = calc_empty ? S_COMMIT : S_SCAN;
            S_SCAN:   if (cnt_q == scan_last) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_COMMIT);

    // ------------------------------------------------------------------
    // Evaluation datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q      <= '0;
            ori_q      <= '0;
            len_q      <= '0;
            wxlo_q     <= '0;
            wxhi_q     <= '0;
            wylo_q     <= '0;
            wyhi_q     <= '0;
            wvert_q    <= 1'b0;
            wspan_q    <= '0;
            woob_q     <= 1'b0;
            wempty_q   <= 1'b1;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            occ_addr_q <= '0;
            dxlo_q     <= '0;
            dxhi_q     <= '0;
            dylo_q     <= '0;
            dyhi_q     <= '0;
            dvalid_q   <= 1'b0;
            dok_q      <= 1'b0;
            doob_q     <= 1'b0;
            dcol_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (update) begin
                        cur_q <= cursor;
                        ori_q <= orientation;
                        len_q <= length;
                    end
                end
                S_CALC: begin
                    wxlo_q   <= seg_xlo;
                    wxhi_q   <= seg_xhi;
                    wylo_q   <= seg_ylo;
                    wyhi_q   <= seg_yhi;
                    wvert_q  <= calc_vert;
                    wspan_q  <= hi_c - lo_c;
                    woob_q   <= calc_oob;
                    wempty_q <= calc_empty;
                    cnt_q    <= '0;
                    acc_q    <= 1'b0;
                    // Empty segments leave the read port untouched
                    if (!calc_empty) occ_addr_q <= {seg_xlo, seg_ylo};
                end
                S_SCAN: begin
                    cnt_q <= cnt_q + 5'd1;
                    // Data for the address of cycle k arrives in cycle k+1
                    if (cnt_q != 5'd0) acc_q <= acc_q | occ_data;
                    if (cnt_q < {1'b0, wspan_q}) begin
                        occ_addr_q <= wvert_q ? {occ_addr_q[7:4], occ_addr_q[3:0] + 4'd1}
                                              : {occ_addr_q[7:4] + 4'd1, occ_addr_q[3:0]};
                    end
                end
                S_COMMIT: begin
                    dxlo_q   <= wxlo_q;
                    dxhi_q   <= wxhi_q;
                    dylo_q   <= wylo_q;
                    dyhi_q   <= wyhi_q;
                    dvalid_q <= !wempty_q;
                    doob_q   <= woob_q;
                    dcol_q   <= acc_q;
                    dok_q    <= !woob_q && !acc_q && !wempty_q;
                end
                default: ;
            endcase
        end
    end

    assign occ_addr     = occ_addr_q;
    assign placement_ok = dok_q;
    assign oob          = doob_q;
    assign collide      = dcol_q;

    // ------------------------------------------------------------------
    // Pixel path: stage 1 converts to grid tiles, stage 2 tests membership
    // ------------------------------------------------------------------
    logic [9:0] tx_d, tyr_d, ty_d;
    logic       ing_d, hit_d;

    always_comb begin
        tx_d  = pixel_x >> TILE_LOG2;
        tyr_d = pixel_y >> TILE_LOG2;
        ty_d  = tyr_d - BAN10;
        // Banner rows are rejected before the subtraction can wrap
        ing_d = (tyr_d >= BAN10) && (tx_d < GRID10) && (ty_d < GRID10);
        hit_d = ing_q && dvalid_q &&
                (tx_q >= {6'd0, dxlo_q}) && (tx_q <= {6'd0, dxhi_q}) &&
                (ty_q >= {6'd0, dylo_q}) && (ty_q <= {6'd0, dyhi_q});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_q    <= '0;
            ty_q    <= '0;
            ing_q   <= 1'b0;
            ghost_q <= 1'b0;
            gok_q   <= 1'b0;
        end else begin
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            ing_q   <= ing_d;
            ghost_q <= hit_d;
            gok_q   <= hit_d && dok_q;
        end
    end

    assign ghost_ship = ghost_q;
    assign ghost_ok   = gok_q;

endmodule

// File: tb/tb_ghost_ship_gen.sv
// Scoreboarded bench for ghost_ship_gen. Stimulus pushes model predictions into
// queues; a negedge monitor pops them when done pulses or a pixel result is due.
module tb_ghost_ship_gen;

    localparam int GRID_N = 10;
    localparam int TL     = 5;
    localparam int BAN    = 3;
    localparam int MAXL   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic [7:0] cursor = '0;
    logic [3:0] orientation = '0;
    logic [3:0] length = '0;
    logic       update = 1'b0;
    logic [7:0] occ_addr;
    logic       occ_data = 1'b0;
    logic       busy, done, placement_ok, oob, collide, ghost_ship, ghost_ok;

    ghost_ship_gen #(
        .GRID_N(GRID_N), .TILE_LOG2(TL), .BANNER_TILES(BAN), .MAX_LEN(MAXL)
    ) dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .cursor(cursor), .orientation(orientation), .length(length),
        .update(update), .occ_addr(occ_addr), .occ_data(occ_data),
        .busy(busy), .done(done), .placement_ok(placement_ok), .oob(oob),
        .collide(collide), .ghost_ship(ghost_ship), .ghost_ok(ghost_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int lat;
        bit ok;
        bit oob;
        bit col;
    } exp_t;

    typedef struct {
        int due;
        bit g;
        bit gok;
    } pix_t;

    exp_t exp_q[$];
    pix_t pix_q[$];
    exp_t post_exp;
    bit   post_pending = 1'b0;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    bit occ[16][16];
    bit m_map[GRID_N][GRID_N];
    bit disp_map[GRID_N][GRID_N];
    bit disp_ok = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Occupancy memory with one cycle of read latency
    always @(posedge clk) occ_data <= occ[occ_addr[7:4]][occ_addr[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Walk the ship tile by tile from the anchor, keeping in-grid tiles.
    task automatic model(input logic [7:0] cur, input logic [3:0] ori,
                         input logic [3:0] len, output exp_t e);
        int cx, cy, dx, dy, n, x, y;
        bit clipped;
        cx = int'(cur[7:4]);
        cy = int'(cur[3:0]);
        dx = 0; dy = 0; n = 0; clipped = 1'b0;
        for (int i = 0; i < GRID_N; i++)
            for (int j = 0; j < GRID_N; j++) m_map[i][j] = 1'b0;
        e.t = 0; e.col = 1'b0;
        case (ori)
            4'd1: dy = -1;
            4'd2: dx = 1;
            4'd4: dy = 1;
            4'd8: dx = -1;
            default: ;
        endcase
        if ((dx == 0 && dy == 0) || len == 0 || cx >= GRID_N || cy >= GRID_N) begin
            e.ok = 1'b0; e.oob = 1'b1; e.lat = 2;
        end else begin
            for (int k = 0; k < int'(len); k++) begin
                x = cx + dx * k;
                y = cy + dy * k;
                if (x >= 0 && x < GRID_N && y >= 0 && y < GRID_N) begin
                    m_map[x][y] = 1'b1;
                    n++;
                    if (occ[x][y]) e.col = 1'b1;
                end else clipped = 1'b1;
            end
            e.oob = clipped || (int'(len) > MAXL);
            e.ok  = !e.oob && !e.col;
            e.lat = n + 3;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_eval(input logic [7:0] cur, input logic [3:0] ori, input logic [3:0] len);
        exp_t e;
        logic [7:0] a0;
        model(cur, ori, len, e);
        @(negedge clk);
        cursor = cur; orientation = ori; length = len; update = 1'b1;
        e.t = cyc;
        a0  = occ_addr;
        exp_q.push_back(e);
        @(negedge clk);
        update = 1'b0;
        wait_idle();
        @(negedge clk);
        if (e.lat == 2) chk("occ_addr_quiet", {24'd0, occ_addr}, {24'd0, a0});
        disp_map = m_map;
        disp_ok  = e.ok;
    endtask

    task automatic pix(input int px, input int py);
        pix_t p;
        int tx, tyr;
        @(negedge clk);
        pixel_x = px[9:0];
        pixel_y = py[9:0];
        tx  = px >> TL;
        tyr = py >> TL;
        p.due = cyc + 2;
        p.g   = 1'b0;
        if (tyr >= BAN && tx < GRID_N && (tyr - BAN) < GRID_N) p.g = disp_map[tx][tyr - BAN];
        p.gok = p.g && disp_ok;
        pix_q.push_back(p);
    endtask

    task automatic sweep();
        for (int x = 0; x < GRID_N; x++)
            for (int y = 0; y < GRID_N; y++)
                if (disp_map[x][y]) pix(x * 32 + 7, (y + BAN) * 32 + 20);
        for (int i = 0; i < 6; i++) pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        pix(5, 95);
        pix(319, 96);
        pix(320, 100);
        pix(0, (BAN + GRID_N) * 32);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_occ();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) occ[i][j] = 1'b0;
    endtask

    // Monitor
    initial begin
        pix_t p;
        forever begin
            @(negedge clk);
            if (post_pending) begin
                post_pending = 1'b0;
                chk("placement_ok", {31'd0, placement_ok}, {31'd0, post_exp.ok});
                chk("oob",          {31'd0, oob},          {31'd0, post_exp.oob});
                chk("collide",      {31'd0, collide},      {31'd0, post_exp.col});
                chk("done_single",  {31'd0, done},         32'd0);
            end
            if (done === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
                else begin
                    post_exp = exp_q.pop_front();
                    chk("done_latency", cyc - post_exp.t, post_exp.lat);
                    post_pending = 1'b1;
                end
            end
            if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
                p = pix_q.pop_front();
                chk("ghost_ship", {31'd0, ghost_ship}, {31'd0, p.g});
                chk("ghost_ok",   {31'd0, ghost_ok},   {31'd0, p.gok});
            end
        end
    end

    initial begin
        exp_t e;
        int r;
        logic [3:0] ro;
        clear_occ();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     {31'd0, busy},         32'd0);
        chk("rst_done",     {31'd0, done},         32'd0);
        chk("rst_ok",       {31'd0, placement_ok}, 32'd0);
        chk("rst_oob",      {31'd0, oob},          32'd0);
        chk("rst_collide",  {31'd0, collide},      32'd0);
        chk("rst_ghost",    {31'd0, ghost_ship},   32'd0);
        chk("rst_ghost_ok", {31'd0, ghost_ok},     32'd0);
        chk("rst_occ_addr", {24'd0, occ_addr},     32'd0);
        rst = 1'b1;
        @(negedge clk);

        // South from (3,3), fully in-grid
        run_eval(8'h33, 4'd4, 4'd4);
        sweep();
        for (int k = 0; k < 4; k++) pix(100, (6 + k) * 32 + 5);
        pix(100, 10 * 32 + 5);
        repeat (3) @(negedge clk);

        // East clipped at right edge
        run_eval(8'h81, 4'd2, 4'd4);
        sweep();

        // North clipped at top, banner rows stay clear
        run_eval(8'h12, 4'd1, 4'd5);
        sweep();
        for (int py = 0; py < 96; py += 16) pix(40, py);
        repeat (3) @(negedge clk);

        // West with one occupied tile
        occ[4][5] = 1'b1;
        run_eval(8'h55, 4'd8, 4'd3);
        sweep();
        clear_occ();

        // Empty segments
        run_eval(8'h33, 4'b0011, 4'd3);
        sweep();
        run_eval(8'h33, 4'd4, 4'd0);
        run_eval(8'hA3, 4'd2, 4'd2);
        run_eval(8'h3C, 4'd4, 4'd2);
        sweep();

        // Over-length but in-grid, full-grid clip, corner single tile
        run_eval(8'h00, 4'd2, 4'd7);
        sweep();
        run_eval(8'h00, 4'd4, 4'd15);
        sweep();
        run_eval(8'h90, 4'd1, 4'd1);
        sweep();

        // Update while scanning is ignored
        model(8'h22, 4'd4, 4'd5, e);
        @(negedge clk);
        cursor = 8'h22; orientation = 4'd4; length = 4'd5; update = 1'b1;
        e.t = cyc;
        exp_q.push_back(e);
        @(negedge clk); update = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cursor = 8'h99; orientation = 4'd2; length = 4'd1; update = 1'b1;
        @(negedge clk); update = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ignored_update_idle", {31'd0, busy}, 32'd0);
        disp_map = m_map;
        disp_ok  = e.ok;
        sweep();

        // Reset mid-SCAN abandons the evaluation
        @(negedge clk);
        cursor = 8'h33; orientation = 4'd4; length = 4'd4; update = 1'b1;
        @(negedge clk); update = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy",     {31'd0, busy},         32'd0);
        chk("midrst_done",     {31'd0, done},         32'd0);
        chk("midrst_ok",       {31'd0, placement_ok}, 32'd0);
        chk("midrst_oob",      {31'd0, oob},          32'd0);
        chk("midrst_collide",  {31'd0, collide},      32'd0);
        chk("midrst_ghost",    {31'd0, ghost_ship},   32'd0);
        chk("midrst_occ_addr", {24'd0, occ_addr},     32'd0);
        rst = 1'b1;
        for (int i = 0; i < GRID_N; i++)
            for (int j = 0; j < GRID_N; j++) disp_map[i][j] = 1'b0;
        disp_ok = 1'b0;
        repeat (4) @(negedge clk);
        sweep();
        run_eval(8'h55, 4'd8, 4'd3);
        sweep();

        // Randomized placements over random maps
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) occ[i][j] = ($urandom_range(0, 7) == 0);
            r = int'($urandom_range(0, 9));
            if (r < 8) ro = 4'(1 << (r % 4));
            else       ro = 4'($urandom_range(0, 15));
            run_eval({4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))}, ro,
                     4'($urandom_range(0, 15)));
            sweep();
        end

        repeat (4) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("pix_queue_drained", pix_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ghost_ship_gen.md
GHOST_SHIP_GEN -- requirements
Module: ghost_ship_gen

Interface
REQ-001 SHALL provide parameters, one per line:
- GRID_N, 10, grid tiles per side (2..15).
- TILE_LOG2, 5, log2 of tile edge in pixels.
- BANNER_TILES, 3, tile rows above the grid reserved for the banner.
- MAX_LEN, 5, largest legal ship length (1..15).

REQ-002 SHALL provide ports, one per line:
- clk, in, 1, system clock; all logic on its rising edge.
- rst, in, 1, synchronous active-low reset.
- pixel_x, in, 10, current display pixel column.
- pixel_y, in, 10, current display pixel row.
- cursor, in, 8, {x[7:4], y[3:0]} anchor tile.
- orientation, in, 4, one-hot NORTH=1, EAST=2, SOUTH=4, WEST=8.
- length, in, 4, requested ship length in tiles.
- update, in, 1, pulse requesting evaluation of the current cursor, orientation and length.
- occ_addr, out, 8, {x,y} occupancy-map read address.
- occ_data, in, 1, occupied bit for occ_addr, valid 1 cycle after the address.
- busy, out, 1, evaluation in progress.
- done, out, 1, single-cycle pulse when an evaluation commits.
- placement_ok, out, 1, committed placement is fully in-grid and collision-free.
- oob, out, 1, committed placement extended outside the grid (clipped).
- collide, out, 1, committed placement overlaps an occupied tile.
- ghost_ship, out, 1, current pixel lies on the committed (clipped) ghost segment.
- ghost_ok, out, 1, equals placement_ok for ghost pixels, 0 elsewhere (colour select).

Function
REQ-003 SHALL implement FSM IDLE -> CALC -> SCAN -> COMMIT -> IDLE. update is accepted only in IDLE; update while busy is ignored.
REQ-004 In IDLE with update=1, SHALL latch cursor, orientation and length into working registers and go to CALC. busy=1 in every state except IDLE.
REQ-005 CALC (1 cycle) SHALL compute the unclipped segment in signed arithmetic at least 6 bits wide:
- NORTH: x=cx, y from cy-len+1 to cy.
- SOUTH: x=cx, y from cy to cy+len-1.
- EAST: y=cy, x from cx to cx+len-1.
- WEST: y=cy, x from cx-len+1 to cx.
REQ-006 CALC SHALL clip the segment to 0..GRID_N-1. oob=1 if any tile was clipped or if length>MAX_LEN.
REQ-007 The segment SHALL be empty, with SCAN skipped and the FSM going directly to COMMIT, when any of the following holds: orientation is not one-hot, length=0, cursor x>=GRID_N, or cursor y>=GRID_N. In that case placement_ok=0, oob=1 and collide=0.
REQ-008 SCAN SHALL issue one occ_addr per cycle from the clipped start tile to the clipped end tile. It SHALL sample occ_data one cycle later and OR the samples into a collide accumulator. SCAN ends once the last sample is taken: clipped length + 1 cycles.
REQ-009 COMMIT SHALL copy the clipped segment, oob, collide and placement_ok = !oob & !collide & nonempty into display registers, pulse done for 1 cycle, and return to IDLE.
REQ-010 Display registers SHALL change only in COMMIT, so the ghost never shows a partially evaluated placement.
REQ-011 The pixel path SHALL be a 2-stage pipeline with pixel-to-ghost_ship latency of exactly 2 cycles:
- Stage 1 registers tile_x = pixel_x>>TILE_LOG2 and tile_y = (pixel_y>>TILE_LOG2) - BANNER_TILES, plus an in_grid flag.
- in_grid=0 when (pixel_y>>TILE_LOG2) < BANNER_TILES, when tile_x>=GRID_N, or when tile_y>=GRID_N. There is no wrap-around.
- Stage 2 sets ghost_ship = in_grid and (tile_x, tile_y) within the committed segment; ghost_ok = ghost_ship & placement_ok.
REQ-012 occ_addr SHALL hold its last value outside SCAN.

Reset
REQ-013 With rst=0 at a clock edge, SHALL set the FSM to IDLE and clear all of the following: busy, done, placement_ok, oob, collide, ghost_ship, ghost_ok, occ_addr, both pipeline stages, and the display segment (made empty).
REQ-014 Reset asserted mid-SCAN SHALL abandon the evaluation with no done pulse. The first update after rst returns to 1 SHALL be accepted normally.

Verification
REQ-015 cursor=8'h33, SOUTH, length=4, empty map, update pulse -> done 7 cycles later (CALC 1 + SCAN 5 + COMMIT 1); placement_ok=1, oob=0; ghost_ship=1 for pixel (x=100, y=(3+3..3+6)*32+5) two cycles after presentation.
REQ-016 cursor=8'h81, EAST, length=4 -> segment clipped to x=8..9, oob=1, placement_ok=1 never asserted; ghost drawn on tiles (8,1) and (9,1) only.
REQ-017 cursor=8'h12, NORTH, length=5 -> y clipped to 0..2, oob=1; no ghost pixels in banner rows (pixel_y<96).
REQ-018 cursor=8'h55, WEST, length=3, occ_data=1 only at address 8'h45 -> collide=1, placement_ok=0, ghost_ok=0 while ghost_ship=1 on tiles x=3..5.
REQ-019 orientation=4'b0011, or length=0 -> done after 2 cycles, no occ_addr activity, ghost_ship=0 everywhere, oob=1.
REQ-020 Second update pulse during SCAN, then rst=0 mid-SCAN -> second update ignored, no done pulse, all outputs 0; next update evaluates correctly.
